// File: rtl/four_bit_adder_reg_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// The producer drives the operands through master; the adder drives results through slave.
interface four_bit_adder_reg_if #(
    parameter int unsigned WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] s;
    logic             cy;
    logic             out_valid;

    modport master (
        output in_valid, a, b, cin,
        input  s, cy, out_valid
    );

    modport slave (
        input  in_valid, a, b, cin,
        output s, cy, out_valid
    );
endinterface

// File: rtl/four_bit_adder_reg.sv
// Registered ripple-carry adder: {cy, s} <= a + b + cin, one cycle after in_valid.
// s/cy hold their last result while in_valid is low; out_valid flags a fresh result.
module four_bit_adder_reg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    four_bit_adder_reg_if.slave  bus
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s_n;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cy_q, cy_d;
    logic             vld_q, vld_d;

    // One full-adder cell per bit, carry rippling upward from cin.
    always_comb begin
        c    = '0;
        s_n  = '0;
        c[0] = bus.cin;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            s_n[i]  = bus.a[i] ^ bus.b[i] ^ c[i];
            c[i+1]  = (bus.a[i] & bus.b[i]) | (bus.b[i] & c[i]) | (bus.a[i] & c[i]);
        end
    end

    always_comb begin
        s_d   = s_q;
        cy_d  = cy_q;
        vld_d = 1'b0;
        if (bus.in_valid) begin
            s_d   = s_n;
            cy_d  = c[WIDTH];
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= '0;
            cy_q  <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            s_q   <= s_d;
            cy_q  <= cy_d;
            vld_q <= vld_d;
        end
    end

    assign bus.s         = s_q;
    assign bus.cy        = cy_q;
    assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_four_bit_adder_reg.sv
// Bench for four_bit_adder_reg: arithmetic reference model checked every cycle,
// plus literal expectations for the documented corner cases.
module tb_four_bit_adder_reg;
    localparam int unsigned WIDTH = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    bit   cmp_en;

    // Reference model state: expected result as a plain integer sum.
    int   exp_sum;
    bit   exp_v;

    four_bit_adder_reg_if #(.WIDTH(WIDTH)) bus ();

    four_bit_adder_reg #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_sum = 0;
            exp_v   = 1'b0;
        end else if (bus.in_valid) begin
            exp_sum = int'(bus.a) + int'(bus.b) + int'(bus.cin);
            exp_v   = 1'b1;
        end else begin
            exp_v   = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_s",  int'(bus.s),         exp_sum % 16);
            check("model_cy", int'(bus.cy),        exp_sum / 16);
            check("model_v",  int'(bus.out_valid), int'(exp_v));
        end
    end

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic ci);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = ci;
    endtask

    task automatic lit(input string name, input int s_req, input int cy_req, input int v_req);
        check({name, "_s"},  int'(bus.s),         s_req);
        check({name, "_cy"}, int'(bus.cy),        cy_req);
        check({name, "_v"},  int'(bus.out_valid), v_req);
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       ci;
        int         s;
        int         cy;
    } vec_t;

    vec_t vecs[7];

    initial begin
        total  = 0;
        bad    = 0;
        cmp_en = 1'b0;
        rst_n  = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 1'b0);

        vecs[0] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 0};
        vecs[1] = '{4'b0001, 4'b0011, 1'b0, 4'b0100, 0};
        vecs[2] = '{4'b1010, 4'b0101, 1'b0, 4'b1111, 0};
        vecs[3] = '{4'b1111, 4'b1111, 1'b0, 4'b1110, 1};
        vecs[4] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1};
        vecs[5] = '{4'b1111, 4'b0001, 1'b1, 4'b0001, 1};
        vecs[6] = '{4'b1011, 4'b1100, 1'b1, 4'b1000, 1};

        repeat (3) @(negedge clk);
        lit("reset", 0, 0, 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].ci);
            @(negedge clk);
            lit($sformatf("vec%0d", i), vecs[i].s, vecs[i].cy, 1);
        end

        // Operands change while not valid: previous result must be held.
        drive(1'b0, 4'h3, 4'h9, 1'b0);
        @(negedge clk);
        lit("hold", 4'b1000, 1, 0);
        drive(1'b0, 4'h7, 4'h2, 1'b1);
        @(negedge clk);
        lit("hold2", 4'b1000, 1, 0);

        for (int n = 0; n < 512; n++) begin
            drive(1'b1, n[3:0], n[7:4], n[8]);
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                drive(1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
                @(negedge clk);
            end
        end

        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
            @(negedge clk);
        end

        // Asynchronous reset between edges, with a non-zero result held beforehand.
        drive(1'b1, 4'hF, 4'hF, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        lit("async_rst", 0, 0, 0);
        @(negedge clk);
        drive(1'b0, 4'h5, 4'h5, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);
        lit("post_rst", 0, 0, 0);
        drive(1'b1, 4'h5, 4'h5, 1'b1);
        @(negedge clk);
        lit("post_rst_first", 4'hB, 0, 1);
        drive(1'b0, 4'h0, 4'h0, 1'b0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
